// File: rtl/execute_lane.sv
// rtl/execute_lane.sv - one VLIW execute lane: ALU, own-result forwarding, iterative multiplier
module execute_lane #(
    parameter int MUL_STEP = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        r2e_valid,
    input  logic [3:0]  r2e_inst,
    input  logic [3:0]  r2e_src1,
    input  logic [3:0]  r2e_src2,
    input  logic [3:0]  r2e_dest,
    input  logic [63:0] r2e_imm,
    input  logic [63:0] r2e_src1data,
    input  logic [63:0] r2e_src2data,
    output logic        e2r_stall,
    output logic        e2w_wr,
    output logic [3:0]  e2w_dest,
    output logic [63:0] e2w_data,
    output logic        e2o_rdvalid,
    output logic [63:0] e2o_rddata
);
    localparam int MUL_CYC = 32 / MUL_STEP;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [3:0] OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_MUL  = 4'h3;
    localparam logic [3:0] OP_LOAD = 4'h4, OP_MOVE = 4'h5, OP_READ = 4'h6, OP_CMP  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8, OP_NAND = 4'h9, OP_NOR  = 4'hA, OP_NOT  = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC, OP_SHR  = 4'hD, OP_ROL  = 4'hE, OP_ROR  = 4'hF;

    logic [0:0]  state;
    logic [63:0] op_a, op_b;
    logic [63:0] alu_res;
    logic [6:0]  sh;
    logic        accept;

    logic [63:0] mul_acc, mul_mcand, mul_pp, mul_acc_next;
    logic [31:0] mul_mplier;
    logic [5:0]  mul_cnt;
    logic [3:0]  mul_dest;
    logic        mul_last;

    assign e2r_stall = (state == ST_MUL);
    assign accept    = r2e_valid && !e2r_stall && !flush;

    // The register file reads stale data when it is written on the same edge,
    // so our own last result overrides the operand it would have supplied.
    always_comb begin
        op_a = (e2w_wr && e2w_dest == r2e_src1) ? e2w_data : r2e_src1data;
        op_b = (e2w_wr && e2w_dest == r2e_src2) ? e2w_data : r2e_src2data;
    end

    assign sh = {3'b000, op_b[3:0]};

    always_comb begin
        alu_res = 64'd0;
        case (r2e_inst)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_LOAD: alu_res = r2e_imm;
            OP_MOVE: alu_res = op_a;
            OP_CMP:  alu_res = {62'd0, op_a < op_b, op_a == op_b};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NAND: alu_res = ~(op_a & op_b);
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_NOT:  alu_res = ~op_a;
            OP_SHL:  alu_res = op_a << sh;
            OP_SHR:  alu_res = op_a >> sh;
            OP_ROL:  alu_res = (op_a << sh) | (op_a >> (7'd64 - sh));
            OP_ROR:  alu_res = (op_a >> sh) | (op_a << (7'd64 - sh));
            default: alu_res = 64'd0;
        endcase
    end

    // Shift-add: retire MUL_STEP multiplier bits per cycle.
    always_comb begin
        mul_pp = 64'd0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mul_mplier[i]) begin
                mul_pp = mul_pp + (mul_mcand << i);
            end
        end
        mul_acc_next = mul_acc + mul_pp;
    end

    assign mul_last = (mul_cnt == 6'(MUL_CYC - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            e2w_wr      <= 1'b0;
            e2w_dest    <= 4'd0;
            e2w_data    <= 64'd0;
            e2o_rdvalid <= 1'b0;
            e2o_rddata  <= 64'd0;
            mul_acc     <= 64'd0;
            mul_mcand   <= 64'd0;
            mul_mplier  <= 32'd0;
            mul_cnt     <= 6'd0;
            mul_dest    <= 4'd0;
        end else begin
            e2w_wr      <= 1'b0;
            e2o_rdvalid <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else if (state == ST_MUL) begin
                mul_acc    <= mul_acc_next;
                mul_mcand  <= mul_mcand << MUL_STEP;
                mul_mplier <= mul_mplier >> MUL_STEP;
                mul_cnt    <= mul_cnt + 6'd1;
                if (mul_last) begin
                    state    <= ST_IDLE;
                    e2w_wr   <= 1'b1;
                    e2w_dest <= mul_dest;
                    e2w_data <= mul_acc_next;
                end
            end else if (accept) begin
                if (r2e_inst == OP_MUL) begin
                    state      <= ST_MUL;
                    mul_acc    <= 64'd0;
                    mul_mcand  <= {32'd0, op_a[31:0]};
                    mul_mplier <= op_b[31:0];
                    mul_cnt    <= 6'd0;
                    mul_dest   <= r2e_dest;
                end else if (r2e_inst == OP_READ) begin
                    e2o_rdvalid <= 1'b1;
                    e2o_rddata  <= op_a;
                end else if (r2e_inst != OP_NOP) begin
                    e2w_wr   <= 1'b1;
                    e2w_dest <= r2e_dest;
                    e2w_data <= alu_res;
                end
            end
        end
    end
endmodule
